// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its entry FIFO.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush dominates push and pop.
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wdata,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q < FIFO_FULL);
      do_pop   = pop && (count_q != '0);
      wr_ptr   = rd_ptr_q + PTR_W'(count_q);
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush) mem_q[wr_ptr] <= wdata;
      end
   end

   // Empty FIFO presents zeros so the decoder never sees a stale word.
   assign count = count_q;
   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding memory request FSM, redirect handling and entry buffering.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RSTn,
   output logic        I_MEM_CSN,
   output logic [31:0] I_MEM_ADDR,
   input  logic        I_MEM_VALID,
   input  logic [31:0] I_MEM_DI,
   output logic [31:0] INSTR,
   output logic [31:0] INSTR_PC,
   output logic        INSTR_VALID,
   input  logic        INSTR_READY,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC
);

   localparam logic [31:0] ALIGN_MASK = ~32'h3;

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q, req_pc_d;
   logic             issue, push, pop;
   logic [CNT_W-1:0] count;
   fetch_entry_t     push_entry, head;

   // Issue is gated by RSTn so the strobe stays inactive for the whole reset.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      push     = 1'b0;
      issue    = RSTn && (state_q == IDLE) && (count < FIFO_FULL) && !REDIRECT;

      unique case (state_q)
         IDLE: if (issue) state_d = WAIT;
         WAIT: begin
            if (I_MEM_VALID) begin
               push    = !REDIRECT;
               state_d = IDLE;
            end else if (REDIRECT) begin
               state_d = DROP;
            end
         end
         DROP: if (I_MEM_VALID) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (REDIRECT) begin
         pc_d = REDIRECT_PC & ALIGN_MASK;
      end else if (issue) begin
         pc_d     = pc_q + PC_STEP;
         req_pc_d = pc_q;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC & ALIGN_MASK;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   assign push_entry = '{instr: I_MEM_DI, pc: req_pc_q};
   assign pop        = INSTR_VALID && INSTR_READY;

   fetch_fifo u_fifo (
      .clk   (CLK),
      .rst_n (RSTn),
      .push  (push),
      .pop   (pop),
      .flush (REDIRECT),
      .wdata (push_entry),
      .count (count),
      .head  (head)
   );

   assign I_MEM_CSN   = !issue;
   assign I_MEM_ADDR  = pc_q;
   assign INSTR_VALID = (count != '0);
   assign INSTR       = head.instr;
   assign INSTR_PC    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table, multi-cycle corner sequences and random traffic vs a queue-based model.
module tb_instr_fetch;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b1;
   logic        I_MEM_CSN, I_MEM_VALID;
   logic [31:0] I_MEM_ADDR, I_MEM_DI;
   logic [31:0] INSTR, INSTR_PC;
   logic        INSTR_VALID, INSTR_READY, REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        w_csn, w_vld;
   logic [31:0] w_addr, w_instr, w_pc;

   always #5 CLK = ~CLK;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RSTn(RSTn), .I_MEM_CSN(I_MEM_CSN), .I_MEM_ADDR(I_MEM_ADDR),
      .I_MEM_VALID(I_MEM_VALID), .I_MEM_DI(I_MEM_DI), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
      .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC));

   // Twin with a wrapping reset PC; same inputs, so its timing tracks the main DUT.
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .CLK(CLK), .RSTn(RSTn), .I_MEM_CSN(w_csn), .I_MEM_ADDR(w_addr),
      .I_MEM_VALID(I_MEM_VALID), .I_MEM_DI(I_MEM_DI), .INSTR(w_instr), .INSTR_PC(w_pc),
      .INSTR_VALID(w_vld), .INSTR_READY(INSTR_READY), .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC));

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   typedef struct {
      bit          rdy;
      bit          csn;
      logic [31:0] addr;
      bit          vld;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic [31:0] addr_w;
      logic [31:0] ipc_w;
   } vec_t;

   int          n_cmp = 0, n_bad = 0, n_req = 0;
   ent_t        mq[$];
   logic [31:0] m_pc, m_req_pc;
   bit          m_out, m_stale, e_issue, e_valid;
   bit          mem_busy;
   int          mem_cnt, lat = 1;
   logic [31:0] mem_addr, s_addr;
   logic        s_csn;
   vec_t        tbl[6];
   bit          found;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0013;
      if (a == 32'h4) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Apply this cycle's inputs, then compare every output with the model.
   task automatic drive(input bit redir, input logic [31:0] rpc, input bit rdy);
      REDIRECT    = redir;
      REDIRECT_PC = rpc;
      INSTR_READY = rdy;
      if (mem_busy && mem_cnt == 1) begin
         I_MEM_VALID = 1'b1;
         I_MEM_DI    = mem_word(mem_addr);
      end else begin
         I_MEM_VALID = 1'b0;
         I_MEM_DI    = $urandom;
      end
      #2;
      e_valid = (mq.size() > 0);
      e_issue = RSTn && !m_out && (mq.size() < 2) && !redir;
      chk1("csn", I_MEM_CSN, !e_issue);
      chk("addr", I_MEM_ADDR, m_pc);
      chk1("valid", INSTR_VALID, e_valid);
      if (e_valid) begin
         chk("instr", INSTR, mq[0].instr);
         chk("instr_pc", INSTR_PC, mq[0].pc);
      end else begin
         chk("instr_empty", INSTR, 32'h0);
         chk("instr_pc_empty", INSTR_PC, 32'h0);
      end
      s_csn  = I_MEM_CSN;
      s_addr = I_MEM_ADDR;
      if (!s_csn) n_req++;
   endtask

   // Advance model and bench memory across the clock edge.
   task automatic tick();
      @(posedge CLK);
      if (REDIRECT) begin
         mq.delete();
         m_pc = REDIRECT_PC & ~32'h3;
         if (m_out) begin
            if (I_MEM_VALID) begin
               m_out   = 1'b0;
               m_stale = 1'b0;
            end else begin
               m_stale = 1'b1;
            end
         end
      end else begin
         if (e_valid && INSTR_READY) void'(mq.pop_front());
         if (m_out && I_MEM_VALID) begin
            if (!m_stale) mq.push_back('{instr: I_MEM_DI, pc: m_req_pc});
            m_out   = 1'b0;
            m_stale = 1'b0;
         end
         if (e_issue) begin
            m_out    = 1'b1;
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
         end
      end
      if (I_MEM_VALID) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (!s_csn) begin
         mem_busy = 1'b1;
         mem_cnt  = lat;
         mem_addr = s_addr;
      end
      #1;
   endtask

   task automatic cyc(input bit redir, input logic [31:0] rpc, input bit rdy);
      drive(redir, rpc, rdy);
      tick();
   endtask

   task automatic do_reset();
      RSTn        = 1'b0;
      REDIRECT    = 1'b0;
      I_MEM_VALID = 1'b0;
      INSTR_READY = 1'b0;
      #1;
      chk1("rst_valid", INSTR_VALID, 1'b0);
      chk("rst_instr", INSTR, 32'h0);
      chk("rst_instr_pc", INSTR_PC, 32'h0);
      chk1("rst_csn", I_MEM_CSN, 1'b1);
      chk("rst_addr", I_MEM_ADDR, 32'h0);
      chk1("rst_csn_w", w_csn, 1'b1);
      chk("rst_addr_w", w_addr, 32'hFFFF_FFFC);
      mq.delete();
      m_pc     = 32'h0;
      m_out    = 1'b0;
      m_stale  = 1'b0;
      mem_busy = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RSTn = 1'b1;
   endtask

   task automatic wait_request(input string nm);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         drive(1'b0, 32'h0, 1'b1);
         if (!s_csn) found = 1'b1;
         tick();
      end
      chk1(nm, found, 1'b1);
   endtask

   task automatic wait_first_valid(input string nm, input logic [31:0] pc);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         drive(1'b0, 32'h0, 1'b1);
         if (INSTR_VALID) begin
            found = 1'b1;
            chk({nm, "_pc"}, INSTR_PC, pc);
            chk({nm, "_instr"}, INSTR, mem_word(pc));
         end
         tick();
      end
      chk1({nm, "_seen"}, found, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      REDIRECT = 1'b0; REDIRECT_PC = '0; INSTR_READY = 1'b0; I_MEM_VALID = 1'b0; I_MEM_DI = '0;
      //            rdy csn addr          vld instr          ipc    addr_w         ipc_w
      tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 32'hFFFF_FFFC, 32'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0,         32'h0, 32'h0,         32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h4, 1'b1, 32'h0000_0013, 32'h0, 32'h0,         32'hFFFF_FFFC};
      tbl[3] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0,         32'h0, 32'h4,         32'h0};
      tbl[4] = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h0010_0093, 32'h4, 32'h4,         32'h0};
      tbl[5] = '{1'b1, 1'b1, 32'hC, 1'b0, 32'h0,         32'h0, 32'h8,         32'h0};
      #2;
      do_reset();

      // Startup with L=1 memory, decoder always ready.
      lat = 1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 32'h0, tbl[i].rdy);
         chk1("tbl_csn", I_MEM_CSN, tbl[i].csn);
         chk("tbl_addr", I_MEM_ADDR, tbl[i].addr);
         chk1("tbl_valid", INSTR_VALID, tbl[i].vld);
         chk("tbl_instr", INSTR, tbl[i].instr);
         chk("tbl_instr_pc", INSTR_PC, tbl[i].ipc);
         chk("tbl_addr_wrap", w_addr, tbl[i].addr_w);
         chk1("tbl_valid_wrap", w_vld, tbl[i].vld);
         chk("tbl_pc_wrap", w_pc, tbl[i].ipc_w);
         tick();
      end

      // Decoder stalled: FIFO fills to two entries, then no more requests.
      n_req = 0;
      repeat (8) cyc(1'b0, 32'h0, 1'b0);
      chk("hold_req_count", 32'(n_req), 32'd1);
      drive(1'b0, 32'h0, 1'b0);
      chk1("hold_csn", I_MEM_CSN, 1'b1);
      chk("hold_head_pc", INSTR_PC, 32'h8);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      chk1("pop_csn", I_MEM_CSN, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      chk1("refill_csn", I_MEM_CSN, 1'b0);
      chk("refill_addr", I_MEM_ADDR, 32'h10);
      chk("refill_head_pc", INSTR_PC, 32'hC);
      tick();
      repeat (6) cyc(1'b0, 32'h0, 1'b1);

      // Redirect while waiting on an L=3 response: stale word dropped.
      lat = 3;
      wait_request("wait_req_l3");
      cyc(1'b1, 32'h0000_0103, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk1("drop_csn_a", I_MEM_CSN, 1'b1);
      chk1("drop_valid_fall", INSTR_VALID, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      chk1("drop_csn_stale_cycle", I_MEM_CSN, 1'b1);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      chk1("drop_restart_csn", I_MEM_CSN, 1'b0);
      chk("drop_restart_addr", I_MEM_ADDR, 32'h100);
      tick();
      wait_first_valid("drop_first", 32'h100);

      // Redirect coinciding with the response: no DROP, restart next cycle.
      lat = 2;
      wait_request("wait_req_l2");
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b1, 32'h0000_0200, 1'b1);
      drive(1'b0, 32'h0, 1'b1);
      chk1("coinc_csn", I_MEM_CSN, 1'b0);
      chk("coinc_addr", I_MEM_ADDR, 32'h200);
      chk1("coinc_valid", INSTR_VALID, 1'b0);
      tick();
      wait_first_valid("coinc_first", 32'h200);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 4);
         cyc(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 2) != 0));
      end

      // Reset while waiting with one entry buffered.
      do_reset();
      lat = 1;
      cyc(1'b0, 32'h0, 1'b0);
      lat = 4;
      cyc(1'b0, 32'h0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      chk1("pre_rst_valid", INSTR_VALID, 1'b1);
      chk1("pre_rst_csn", I_MEM_CSN, 1'b1);
      do_reset();
      drive(1'b0, 32'h0, 1'b1);
      chk1("restart_csn", I_MEM_CSN, 1'b0);
      chk("restart_addr", I_MEM_ADDR, 32'h0);
      tick();
      for (int i = 0; i < 200; i++) begin
         lat = $urandom_range(1, 3);
         cyc(($urandom_range(0, 15) == 0), $urandom, $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage placed directly upstream of the control decoder. Holds the PC and issues word reads to instruction memory with at most one request outstanding. Buffers returned words with their PC in a 2-entry FIFO and presents them to the decoder over a valid/ready handshake. Branch/jump resolution redirects it: the FIFO is flushed and any in-flight stale response is discarded.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- CLK  in  1  clock, all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- I_MEM_CSN  out  1  active-low request strobe; one request per low cycle.
- I_MEM_ADDR  out  32  byte address of request; bits [1:0] always 0.
- I_MEM_VALID  in  1  response strobe, one cycle per request, at least 1 cycle after the request.
- I_MEM_DI  in  32  response data, valid with I_MEM_VALID.
- INSTR  out  32  head instruction to the decoder.
- INSTR_PC  out  32  PC of the head instruction.
- INSTR_VALID  out  1  head entry present.
- INSTR_READY  in  1  decoder accepts the head this cycle.
- REDIRECT  in  1  one-cycle pulse: flush and restart at REDIRECT_PC.
- REDIRECT_PC  in  32  target; bits [1:0] forced to 0 on load.

## Operation
- State: PC reg, FIFO count (0..2), FSM {IDLE, WAIT, DROP}.
- Issue rule: in IDLE with count<2 and REDIRECT=0, drive I_MEM_CSN=0, I_MEM_ADDR=PC.
  - Next state is WAIT.
  - PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Issue is combinational from state, count and REDIRECT; otherwise I_MEM_CSN=1 and I_MEM_ADDR holds PC.
- WAIT:
  - I_MEM_VALID=1: push {I_MEM_DI, PC-4 captured at issue} into FIFO; go to IDLE.
  - Room is guaranteed because issue required count<2.
- DROP: I_MEM_VALID=1 discards the response and goes to IDLE; otherwise stay in DROP. Never issues.
- Pop when INSTR_VALID & INSTR_READY. Push and pop in the same cycle leave count unchanged.
- REDIRECT=1 (highest priority):
  - PC <= {REDIRECT_PC[31:2], 2'b00}.
  - FIFO cleared to count=0.
  - No issue that cycle.
- REDIRECT FSM transitions:
  - IDLE -> IDLE.
  - WAIT with I_MEM_VALID=0 -> DROP.
  - WAIT with I_MEM_VALID=1 -> IDLE; response discarded, no push.
  - DROP -> DROP, or IDLE if I_MEM_VALID=1 that cycle.
- A transfer (VALID&READY) in the redirect cycle still counts as delivered. Its entry is removed by the flush regardless.
- I_MEM_VALID in IDLE is a protocol error and is ignored.
- INSTR/INSTR_PC show the FIFO head when count>0, and 0 when count=0.

## Timing
- Reset (RSTn=0, immediate):
  - PC=RESET_PC, FSM=IDLE, count=0, FIFO entries 0.
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0.
  - I_MEM_CSN=1 while RSTn=0.
- Reset mid-operation: the outstanding response is not tracked. Memory is reset alongside.
- First cycle after RSTn rises: I_MEM_CSN=0, I_MEM_ADDR=RESET_PC.
- Memory latency L>=1 cycles: response in cycle t+L, pushed at that edge, INSTR_VALID=1 in cycle t+L+1.
- No bypass from I_MEM_DI to INSTR.
- Next issue earliest in cycle t+L+1. Steady-state throughput is one word per L+1 cycles.
- Redirect in cycle r: first request to the target in cycle r+1 if the FSM returns to IDLE at that edge. Otherwise one cycle after the stale response.
- INSTR_VALID falls in cycle r+1 after a redirect in cycle r.
- INSTR_VALID and INSTR/INSTR_PC are registered and stable while VALID=1 and READY=0.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DROP}.
  - fetch_entry_t struct {instr[31:0], pc[31:0]}.
  - Constants FIFO_DEPTH=2 and PC_STEP=4.
- Sub-module fetch_fifo: 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush (flush dominant), count, head.
  - Asynchronous active-low reset.
- Top instr_fetch holds the PC, FSM, issue logic and redirect logic.

## Test plan
- Reset then L=1 memory returning words 0x00000013, 0x00100093, READY=1.
  - Requests to 0x0 and 0x4.
  - INSTR_VALID first in cycle 3 with INSTR=0x00000013, INSTR_PC=0x0.
  - Then 0x00100093 at PC 0x4.
- READY=0 held: exactly 2 entries fill, then I_MEM_CSN stays 1.
  - Raising READY for one cycle pops 0x0 and triggers one new request.
- REDIRECT to 0x00000103 while in WAIT (L=3): stale response discarded.
  - FSM passes through DROP.
  - Next request address 0x00000100.
  - First delivered INSTR_PC=0x100.
- REDIRECT in the same cycle as I_MEM_VALID: no push, no DROP state, request to the target next cycle.
- RESET_PC=32'hFFFF_FFFC: second request address 0x00000000.
- RSTn asserted mid-WAIT with 1 FIFO entry: INSTR_VALID=0 and I_MEM_CSN=1 immediately; fetch restarts at RESET_PC.
